// File: rtl/axi_b_resp_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_b_resp_router: steers slave B responses back to AW-granted masters   |
// | in AW order, through a one-entry registered output stage.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_b_resp_router #(
  parameter int NUM_M = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] aw_sel,
  input  logic             aw_fire,
  output logic             aw_ready,
  input  logic             s_bvalid,
  input  logic [1:0]       s_bresp,
  output logic             s_bready,
  output logic [NUM_M-1:0] m_bvalid,
  output logic [1:0]       m_bresp,
  input  logic [NUM_M-1:0] m_bready,
  output logic [2:0]       outstanding,
  output logic             err_sel,
  output logic             err_unexp
);

  localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  logic [2:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       count;
  logic             obuf_v;
  logic [2:0]       obuf_idx;
  logic [1:0]       obuf_resp;

  logic             sel_onehot;
  logic [2:0]       sel_idx;
  logic             push;
  logic             pop;
  logic             drain;

  // Binary encode of the AW grant; only meaningful when it is one-hot.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (aw_sel[k]) sel_idx = 3'(k);
    end
  end

  always_comb begin
    m_bvalid = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_bvalid[i] = obuf_v && (obuf_idx == 3'(i));
    end
  end

  assign sel_onehot  = $onehot(aw_sel);
  assign aw_ready    = (count != FULL_CNT);
  assign push        = aw_fire & aw_ready & sel_onehot;
  // Only the selected master's ready matters: m_bvalid is at most one-hot.
  assign drain       = |(m_bvalid & m_bready);
  assign s_bready    = (count != 3'd0) & (~obuf_v | drain);
  assign pop         = s_bvalid & s_bready;
  assign m_bresp     = obuf_v ? obuf_resp : 2'b00;
  assign outstanding = count;

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sel_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      obuf_v    <= 1'b0;
      obuf_idx  <= '0;
      obuf_resp <= '0;
      err_sel   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + 3'(push) - 3'(pop);

      if (pop) begin
        obuf_v    <= 1'b1;
        obuf_idx  <= fifo_mem[rd_ptr];
        obuf_resp <= s_bresp;
      end else if (drain) begin
        obuf_v <= 1'b0;
      end

      if (aw_fire && !sel_onehot)        err_sel   <= 1'b1;
      if (s_bvalid && (count == 3'd0))   err_unexp <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_b_resp_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_b_resp_router: directed vectors with hand-computed expectations.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi_b_resp_router;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] aw_sel = '0;
  logic       aw_fire = 1'b0;
  logic       aw_ready;
  logic       s_bvalid = 1'b0;
  logic [1:0] s_bresp = '0;
  logic       s_bready;
  logic [5:0] m_bvalid;
  logic [1:0] m_bresp;
  logic [5:0] m_bready = '0;
  logic [2:0] outstanding;
  logic       err_sel;
  logic       err_unexp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_b_resp_router #(.NUM_M(6), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aw_sel     (aw_sel),
    .aw_fire    (aw_fire),
    .aw_ready   (aw_ready),
    .s_bvalid   (s_bvalid),
    .s_bresp    (s_bresp),
    .s_bready   (s_bready),
    .m_bvalid   (m_bvalid),
    .m_bresp    (m_bresp),
    .m_bready   (m_bready),
    .outstanding(outstanding),
    .err_sel    (err_sel),
    .err_unexp  (err_unexp)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_aw_ready"},  8'(aw_ready),    8'd1);
    check_eq({tag, "_s_bready"},  8'(s_bready),    8'd0);
    check_eq({tag, "_m_bvalid"},  8'(m_bvalid),    8'd0);
    check_eq({tag, "_m_bresp"},   8'(m_bresp),     8'd0);
    check_eq({tag, "_outst"},     8'(outstanding), 8'd0);
    check_eq({tag, "_err_sel"},   8'(err_sel),     8'd0);
    check_eq({tag, "_err_unexp"}, 8'(err_unexp),   8'd0);
  endtask

  task automatic push_one(input logic [5:0] sel);
    aw_fire = 1'b1;
    aw_sel  = sel;
    tick();
    aw_fire = 1'b0;
    aw_sel  = '0;
  endtask

  initial begin
    // ---------------- reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_outputs("idle");

    // ---------------- in-order return to masters 2 then 5
    m_bready = 6'h3F;
    push_one(6'b000100);
    check_eq("io_outst1", 8'(outstanding), 8'd1);
    push_one(6'b100000);
    check_eq("io_outst2", 8'(outstanding), 8'd2);
    s_bvalid = 1'b1;
    s_bresp  = 2'd0;
    settle();
    check_eq("io_sbready", 8'(s_bready), 8'd1);
    tick();
    s_bresp = 2'd2;
    settle();
    check_eq("io_mv0", 8'(m_bvalid), 8'b000100);
    check_eq("io_mr0", 8'(m_bresp),  8'd0);
    check_eq("io_sbready_drain", 8'(s_bready), 8'd1);
    tick();
    s_bvalid = 1'b0;
    settle();
    check_eq("io_mv1", 8'(m_bvalid), 8'b100000);
    check_eq("io_mr1", 8'(m_bresp),  8'd2);
    check_eq("io_outst0", 8'(outstanding), 8'd0);
    tick();
    check_eq("io_mv_idle", 8'(m_bvalid), 8'd0);
    check_eq("io_mr_idle", 8'(m_bresp),  8'd0);

    // ---------------- fill to full, refuse pushes
    m_bready = 6'h00;
    push_one(6'b000100);
    push_one(6'b000100);
    push_one(6'b000001);
    push_one(6'b001000);
    check_eq("full_aw_ready", 8'(aw_ready),    8'd0);
    check_eq("full_outst",    8'(outstanding), 8'd4);
    push_one(6'b010000);
    check_eq("full_refused", 8'(outstanding), 8'd4);
    // pop and attempted push in the same cycle while full
    aw_fire  = 1'b1;
    aw_sel   = 6'b010000;
    s_bvalid = 1'b1;
    s_bresp  = 2'd1;
    settle();
    check_eq("full_pp_sbready", 8'(s_bready), 8'd1);
    check_eq("full_pp_awready", 8'(aw_ready), 8'd0);
    tick();
    aw_fire = 1'b0;
    aw_sel  = '0;
    check_eq("full_pp_outst",   8'(outstanding), 8'd3);
    check_eq("full_pp_awready1", 8'(aw_ready),   8'd1);
    check_eq("full_pp_mv",      8'(m_bvalid),    8'b000100);

    // ---------------- stall master 2 with a second response pending
    s_bresp  = 2'd3;
    m_bready = 6'b111011;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_eq("stall_sbready", 8'(s_bready),    8'd0);
      check_eq("stall_mv",      8'(m_bvalid),    8'b000100);
      check_eq("stall_mr",      8'(m_bresp),     8'd1);
      check_eq("stall_outst",   8'(outstanding), 8'd3);
      tick();
    end
    m_bready = 6'h3F;
    settle();
    check_eq("rel_sbready", 8'(s_bready), 8'd1);
    tick();
    s_bvalid = 1'b0;
    check_eq("rel_mv",    8'(m_bvalid),    8'b000100);
    check_eq("rel_mr",    8'(m_bresp),     8'd3);
    check_eq("rel_outst", 8'(outstanding), 8'd2);
    tick();
    check_eq("rel_drained", 8'(m_bvalid), 8'd0);

    // ---------------- bad select
    push_one(6'b000011);
    check_eq("bad_err_sel", 8'(err_sel),     8'd1);
    check_eq("bad_outst",   8'(outstanding), 8'd2);

    // drain the two remaining entries (masters 0 and 3)
    s_bvalid = 1'b1;
    s_bresp  = 2'd0;
    tick();
    check_eq("dr_mv0", 8'(m_bvalid), 8'b000001);
    tick();
    s_bvalid = 1'b0;
    check_eq("dr_mv3",    8'(m_bvalid),    8'b001000);
    check_eq("dr_outst0", 8'(outstanding), 8'd0);
    tick();
    check_eq("dr_idle",       8'(m_bvalid),  8'd0);
    check_eq("dr_unexp_clr",  8'(err_unexp), 8'd0);

    // ---------------- unexpected response with empty FIFO
    s_bvalid = 1'b1;
    s_bresp  = 2'd2;
    settle();
    check_eq("unexp_sbready", 8'(s_bready), 8'd0);
    tick();
    check_eq("unexp_err",     8'(err_unexp), 8'd1);
    check_eq("unexp_mv",      8'(m_bvalid),  8'd0);
    check_eq("unexp_sbready2", 8'(s_bready), 8'd0);
    check_eq("err_sel_sticky", 8'(err_sel),  8'd1);
    s_bvalid = 1'b0;

    // ---------------- async reset mid-flight
    m_bready = 6'h00;
    push_one(6'b000010);
    push_one(6'b000010);
    push_one(6'b010000);
    push_one(6'b000001);
    s_bvalid = 1'b1;
    s_bresp  = 2'd2;
    tick();
    s_bvalid = 1'b0;
    check_eq("ar_pre_outst", 8'(outstanding), 8'd3);
    check_eq("ar_pre_mv",    8'(m_bvalid),    8'b000010);
    check_eq("ar_pre_mr",    8'(m_bresp),     8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_b_resp_router.md
# axi_b_resp_router

Write-response return path paired with the AW-channel arbiter. Each accepted AW handshake records the granting master's index in an in-order tracking FIFO. Slave B responses are then steered back to the originating master in the same order, through a one-entry registered output stage with full valid/ready handshaking. The block sits between the shared slave B channel and the six master B channels, and applies back-pressure to AW when too many writes are outstanding.

## Interface
Parameters:
- NUM_M, 6, number of masters; index width is 3 bits.
- DEPTH, 4, tracking FIFO entries, power of two.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- aw_sel  input  6  one-hot AW grant from the arbiter.
- aw_fire  input  1  AW handshake completed this cycle.
- aw_ready  output  1  tracking FIFO not full; AW must be gated with it.
- s_bvalid  input  1  slave B response valid.
- s_bresp  input  2  slave B response code.
- s_bready  output  1  router accepts the slave response.
- m_bvalid  output  6  per-master B valid; at most one bit is set.
- m_bresp  output  2  response code, shared by all masters.
- m_bready  input  6  per-master B ready.
- outstanding  output  3  FIFO occupancy, 0..DEPTH.
- err_sel  output  1  sticky: aw_fire arrived with aw_sel not exactly one-hot.
- err_unexp  output  1  sticky: s_bvalid arrived while the FIFO was empty.

## Operation
- Push: a push happens when aw_fire=1, aw_ready=1 and aw_sel is exactly one-hot. The push writes the encoded index (bit k gives k) at the write pointer.
- Bad select: aw_fire=1 with aw_sel zero or multi-hot gives no push, and err_sel sets.
- aw_ready = (count != DEPTH). This is combinational from registered count only. A push is refused at full even if a pop happens in the same cycle.
- Output stage holds: obuf_v, obuf_idx[2:0], obuf_resp[1:0].
- Output mapping: m_bvalid[i] = obuf_v & (obuf_idx==i). m_bresp = obuf_resp while obuf_v=1, else 0.
- Drain: drain = obuf_v & m_bready[obuf_idx]. m_bready bits of non-selected masters are ignored.
- s_bready = (count != 0) & (!obuf_v | drain).
- Pop: a pop happens when s_bvalid & s_bready. On a pop:
  - obuf_idx ← FIFO head;
  - obuf_resp ← s_bresp;
  - obuf_v ← 1;
  - the read pointer advances.
- Drain without pop: obuf_v ← 0.
- Count: count += push - pop. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from count, not from the pointers.
- Empty-FIFO response: s_bvalid=1 with count=0 sets err_unexp. s_bready stays 0, so the response stalls and is never dropped.
- Error flags: err_sel and err_unexp clear only on reset.
- Response codes: s_bresp is passed through unmodified, including SLVERR (2) and DECERR (3).
- Master ordering: responses for one master return in AW order. The global order equals the AW order.

## Timing
- Reset values while rst_n=0 (asynchronous):
  - count=0, outstanding=0, pointers=0, obuf_v=0;
  - m_bvalid=0, m_bresp=0, s_bready=0;
  - aw_ready=1, err_sel=0, err_unexp=0.
- Push to poppable: a push in cycle N is visible in count at N+1. s_bready can first rise at N+1, so the minimum AW-to-B acceptance gap is 1 cycle.
- Pop to master valid: a pop in cycle N gives m_bvalid at N+1.
- Throughput: with m_bready held high, one response per cycle is sustained (pop and drain in the same cycle).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Stability: m_bvalid and m_bresp stay stable until drained; they never change while a master is stalled.
- Reset mid-operation: all in-flight tracking and any held response are discarded. No partial output persists after rst_n falls.

## Test plan
- Reset then idle: aw_ready=1, s_bready=0, m_bvalid=0, outstanding=0.
- In-order return, m_bready=6'h3F:
  - stimulus: AW fires for aw_sel 6'b000100, then 6'b100000;
  - slave returns s_bresp 0 then 2 on consecutive cycles;
  - required: m_bvalid=6'b000100 with m_bresp 0, then 6'b100000 with m_bresp 2 on the next cycle;
  - required: outstanding returns to 0.
- Full back-pressure:
  - stimulus: 4 pushes;
  - required: aw_ready=0 and outstanding=4;
  - stimulus: aw_fire while full;
  - required: no push, count stays 4;
  - stimulus: pop and push in the same cycle;
  - required: push refused; aw_ready=1 on the next cycle.
- Master stall:
  - stimulus: hold m_bready[2]=0 with obuf for master 2 and a second response pending;
  - required: s_bready=0, m_bvalid/m_bresp stable for 5 cycles;
  - stimulus: release m_bready[2];
  - required: the next response appears 1 cycle later.
- Errors:
  - stimulus: aw_fire with aw_sel=6'b000011;
  - required: err_sel=1 and outstanding unchanged;
  - stimulus: s_bvalid with an empty FIFO;
  - required: err_unexp=1 and s_bready=0.
- Async reset mid-flight: with 3 outstanding and obuf_v=1, drop rst_n mid-cycle. Required: all outputs reach reset values immediately, without waiting for a clock edge.
